// File: rtl/pc_redirect_controller_pkg.sv
// Shared definitions for the PC redirect controller: FSM state codes, redirect
// source codes and the default reset PC.
package pc_redirect_controller_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_JR  = 2'd2;
    localparam logic [1:0] SRC_J   = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] target;
        logic [1:0]  src;
        logic        misalign;
    } redirect_t;

endpackage

// File: rtl/pc_redirect_controller_target_calc.sv
// Combinational redirect target formation: branch (sign-extended word offset),
// jump (region concat) and jr (forced word alignment with misalign flag).
module pc_redirect_controller_target_calc (
    input  logic [3:0]  pc_hi_i,
    input  logic [31:0] branch_pc_plus4_i,
    input  logic [15:0] branch_offset_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] branch_target_o,
    output logic [31:0] jump_target_o,
    output logic [31:0] jr_target_o,
    output logic        jr_misaligned_o
);

    logic [31:0] branch_disp;

    assign branch_disp     = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign branch_target_o = branch_pc_plus4_i + branch_disp;
    assign jump_target_o   = {pc_hi_i, jump_index_i, 2'b00};
    assign jr_target_o     = {jr_target_i[31:2], 2'b00};
    assign jr_misaligned_o = |jr_target_i[1:0];

endmodule

// File: rtl/pc_redirect_controller.sv
// Program counter owner: arbitrates branch/jr/jump redirects, defers them under
// stall, and generates the registered IF/ID flush window.
module pc_redirect_controller
    import pc_redirect_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchReq,
    input  logic        BranchTaken,
    input  logic [31:0] BranchPCPlus4,
    input  logic [15:0] BranchOffset,
    input  logic        JumpReq,
    input  logic [25:0] JumpIndex,
    input  logic        JrReq,
    input  logic [31:0] JrTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        Redirect,
    output logic        AlignErr
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic        align_q, align_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    redirect_t   pend_q, pend_d;

    logic [31:0] br_target, j_target, jr_target;
    logic        jr_mis;
    logic        br_taken;
    redirect_t   req;
    redirect_t   apply;

    pc_redirect_controller_target_calc u_target_calc (
        .pc_hi_i          (PCPlus4[31:28]),
        .branch_pc_plus4_i(BranchPCPlus4),
        .branch_offset_i  (BranchOffset),
        .jump_index_i     (JumpIndex),
        .jr_target_i      (JrTarget),
        .branch_target_o  (br_target),
        .jump_target_o    (j_target),
        .jr_target_o      (jr_target),
        .jr_misaligned_o  (jr_mis)
    );

    assign PC       = pc_q;
    assign PCPlus4  = pc_q + 32'd4;
    assign Flush    = flush_q;
    assign Redirect = redir_q;
    assign AlignErr = align_q;
    assign br_taken = BranchReq & BranchTaken;

    always_comb begin
        req = '{target: PCPlus4, src: SRC_SEQ, misalign: 1'b0};
        if (br_taken) begin
            req = '{target: br_target, src: SRC_BR, misalign: 1'b0};
        end else if (JrReq) begin
            req = '{target: jr_target, src: SRC_JR, misalign: jr_mis};
        end else if (JumpReq) begin
            req = '{target: j_target, src: SRC_J, misalign: 1'b0};
        end
    end

    always_comb begin
        pc_d    = pc_q;
        flush_d = flush_q;
        redir_d = 1'b0;
        align_d = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        apply   = req;

        case (state_q)
            ST_RUN: begin
                if (req.src != SRC_SEQ) begin
                    if (Stall) begin
                        pend_d  = req;
                        state_d = ST_PEND;
                    end else begin
                        pc_d    = req.target;
                        redir_d = 1'b1;
                        align_d = req.misalign;
                        flush_d = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_FLUSH;
                    end
                end else if (!Stall) begin
                    pc_d = PCPlus4;
                end
            end
            ST_PEND: begin
                // A taken branch is older than the latched jump/jr, so it supersedes it.
                apply = pend_q;
                if (br_taken && pend_q.src != SRC_BR) begin
                    apply = req;
                end
                if (Stall) begin
                    pend_d = apply;
                end else begin
                    pc_d    = apply.target;
                    redir_d = 1'b1;
                    align_d = apply.misalign;
                    flush_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    pend_d  = '{target: '0, src: SRC_SEQ, misalign: 1'b0};
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!Stall) begin
                    pc_d = PCPlus4;
                end
                if (cnt_q == 3'd0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                flush_d = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            align_q <= 1'b0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= '{target: '0, src: SRC_SEQ, misalign: 1'b0};
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            align_q <= align_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Scoreboard bench: two controllers (FLUSH_CYCLES 1 and 3) share stimulus;
// each cycle's expected outputs for one selected instance are queued and checked.
module tb_pc_redirect_controller;

    logic        Clk;
    logic        Reset, Stall, BranchReq, BranchTaken, JumpReq, JrReq;
    logic [31:0] BranchPCPlus4, JrTarget;
    logic [15:0] BranchOffset;
    logic [25:0] JumpIndex;
    logic [31:0] PC1, PCPlus4_1, PC3, PCPlus4_3;
    logic        Flush1, Redirect1, AlignErr1, Flush3, Redirect3, AlignErr3;

    typedef struct {
        bit          sel;
        logic [31:0] pc;
        logic        fl;
        logic        rd;
        logic        al;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pc_redirect_controller #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchReq(BranchReq),
        .BranchTaken(BranchTaken), .BranchPCPlus4(BranchPCPlus4), .BranchOffset(BranchOffset),
        .JumpReq(JumpReq), .JumpIndex(JumpIndex), .JrReq(JrReq), .JrTarget(JrTarget),
        .PC(PC1), .PCPlus4(PCPlus4_1), .Flush(Flush1), .Redirect(Redirect1), .AlignErr(AlignErr1)
    );

    pc_redirect_controller #(.RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchReq(BranchReq),
        .BranchTaken(BranchTaken), .BranchPCPlus4(BranchPCPlus4), .BranchOffset(BranchOffset),
        .JumpReq(JumpReq), .JumpIndex(JumpIndex), .JrReq(JrReq), .JrTarget(JrTarget),
        .PC(PC3), .PCPlus4(PCPlus4_3), .Flush(Flush3), .Redirect(Redirect3), .AlignErr(AlignErr3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
                check32("PC3", PC3, e.pc);
                check32("PCPlus4_3", PCPlus4_3, e.pc + 32'd4);
                check1("Flush3", Flush3, e.fl);
                check1("Redirect3", Redirect3, e.rd);
                check1("AlignErr3", AlignErr3, e.al);
            end else begin
                check32("PC1", PC1, e.pc);
                check32("PCPlus4_1", PCPlus4_1, e.pc + 32'd4);
                check1("Flush1", Flush1, e.fl);
                check1("Redirect1", Redirect1, e.rd);
                check1("AlignErr1", AlignErr1, e.al);
            end
        end
    end

    task automatic clr();
        Reset = 1'b0; Stall = 1'b0; BranchReq = 1'b0; BranchTaken = 1'b0;
        BranchPCPlus4 = '0; BranchOffset = '0; JumpReq = 1'b0; JumpIndex = '0;
        JrReq = 1'b0; JrTarget = '0;
    endtask

    task automatic tick(input bit sel, input logic [31:0] pc, input logic fl, input logic rd,
                        input logic al);
        exp_t e;
        e.sel = sel; e.pc = pc; e.fl = fl; e.rd = rd; e.al = al;
        q.push_back(e);
        @(negedge Clk);
        clr();
    endtask

    task automatic branch(input logic [31:0] pc4, input logic [15:0] off);
        BranchReq = 1'b1; BranchTaken = 1'b1; BranchPCPlus4 = pc4; BranchOffset = off;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        // Reset and sequential fetch up to 0x40
        Reset = 1'b1; tick(0, 32'h0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) tick(0, 32'(i * 4), 0, 0, 0);

        // Backward taken branch
        branch(32'h44, 16'hFFFE); tick(0, 32'h3C, 1, 1, 0);
        tick(0, 32'h40, 0, 0, 0);

        // Branch beats simultaneous jump
        branch(32'h100, 16'h0004); JumpReq = 1'b1; JumpIndex = 26'h40;
        tick(0, 32'h110, 1, 1, 0);
        tick(0, 32'h114, 0, 0, 0);

        // Jump deferred under 3 stall cycles
        for (int i = 0; i < 3; i++) begin
            JumpReq = 1'b1; JumpIndex = 26'h40; Stall = 1'b1;
            tick(0, 32'h114, 0, 0, 0);
        end
        tick(0, 32'h100, 1, 1, 0);
        tick(0, 32'h104, 0, 0, 0);
        Stall = 1'b1; tick(0, 32'h104, 0, 0, 0);
        tick(0, 32'h108, 0, 0, 0);

        // Wrap from top of address space
        JrReq = 1'b1; JrTarget = 32'hFFFF_FFFC; tick(0, 32'hFFFF_FFFC, 1, 1, 0);
        tick(0, 32'h0, 0, 0, 0);
        tick(0, 32'h4, 0, 0, 0);

        // Pending jr replaced by taken branch
        JrReq = 1'b1; JrTarget = 32'h500; Stall = 1'b1; tick(0, 32'h4, 0, 0, 0);
        branch(32'h20, 16'h0008); Stall = 1'b1; tick(0, 32'h4, 0, 0, 0);
        tick(0, 32'h40, 1, 1, 0);
        tick(0, 32'h44, 0, 0, 0);

        // Misaligned jr with a 3-cycle flush window
        Reset = 1'b1; tick(1, 32'h0, 0, 0, 0);
        JrReq = 1'b1; JrTarget = 32'h2003; tick(1, 32'h2000, 1, 1, 1);
        JumpReq = 1'b1; JumpIndex = 26'h40; Stall = 1'b1; tick(1, 32'h2000, 1, 0, 0);
        JumpReq = 1'b1; JumpIndex = 26'h40; tick(1, 32'h2004, 1, 0, 0);
        JumpReq = 1'b1; JumpIndex = 26'h40; tick(1, 32'h2008, 0, 0, 0);
        tick(1, 32'h200C, 0, 0, 0);

        // Reset while pending
        Reset = 1'b1; tick(0, 32'h0, 0, 0, 0);
        JumpReq = 1'b1; JumpIndex = 26'h40; Stall = 1'b1; tick(0, 32'h0, 0, 0, 0);
        Reset = 1'b1; tick(0, 32'h0, 0, 0, 0);
        tick(0, 32'h4, 0, 0, 0);
        tick(0, 32'h8, 0, 0, 0);

        // Reset mid-flush
        JumpReq = 1'b1; JumpIndex = 26'h80; tick(1, 32'h200, 1, 1, 0);
        Reset = 1'b1; tick(1, 32'h0, 0, 0, 0);
        tick(1, 32'h4, 0, 0, 0);
        tick(1, 32'h8, 0, 0, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge Clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 expectations left", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
